// File: rtl/apb_interface_2_pkg.sv
// Shared definitions for the APB-to-RF serial bridge: register map, CONFIG layout
// and the packet sync pattern.
package apb_interface_2_pkg;

  localparam logic [5:0] OFF_CFG  = 6'h00;
  localparam logic [5:0] OFF_DATA = 6'h04;
  localparam logic [5:0] OFF_CMD  = 6'h0C;

  localparam int CMD_START_BIT = 1;

  // CONFIG = {2'b00, MODE, SLAVE, SCK}; the top two bits are never stored
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] slave;
    logic [1:0] sck;
  } cfg_t;

  localparam cfg_t CFG_RST = '{mode: 2'b00, slave: 2'b00, sck: 2'b01};

  // Sync framing: 6 ones at the head, 5 ones mid-packet, 8 ones at the tail
  localparam logic [63:0] SYNC_MASK = 64'hFC00_001F_0000_00FF;
  localparam logic [63:0] SYNC_VAL  = 64'hFC00_001F_0000_00FF;

  function automatic logic [3:0] onehot4(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/apb_interface_2_rf_bit_recovery.sv
// Pulse-position bit recovery: an rfin edge yields a 1 after SAMPLE_DLY cycles,
// silence yields a 0 on timeout; recovered bits shift into a 64-bit register.
module rf_bit_recovery #(
  parameter int SAMPLE_DLY = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_rfin,
  input  logic        i_clr,
  input  logic [31:0] i_period,
  output logic        o_sh_en,
  output logic [63:0] o_shreg
);

  logic        r_rf_q;
  logic        r_bit;
  logic        r_sh_en;
  logic [31:0] r_cnt;
  logic [63:0] r_shreg;
  logic        w_rise;
  logic        w_fire;

  assign w_rise  = i_rfin & ~r_rf_q;
  assign w_fire  = (r_cnt == 32'd0);
  assign o_sh_en = r_sh_en;
  assign o_shreg = r_shreg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rf_q  <= 1'b0;
      r_bit   <= 1'b0;
      r_sh_en <= 1'b0;
      r_cnt   <= 32'd0;
      r_shreg <= 64'd0;
    end else begin
      r_rf_q  <= i_rfin;
      r_sh_en <= 1'b0;
      if (i_clr) r_shreg <= 64'd0;
      if (!i_en) begin
        r_cnt <= i_period - 32'd1;
        r_bit <= 1'b0;
      end else begin
        if (w_fire) begin
          r_sh_en <= 1'b1;
          if (!i_clr) r_shreg <= {r_shreg[62:0], r_bit};
          r_bit <= 1'b0;
          // A 1 lands mid-slot, so the next silent slot ends half a period later
          r_cnt <= (r_bit ? i_period + (i_period >> 1) : i_period) - 32'd1;
        end else begin
          r_cnt <= r_cnt - 32'd1;
        end
        // An edge always wins over a pending timeout
        if (w_rise) begin
          r_cnt <= 32'(SAMPLE_DLY - 1);
          r_bit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_interface_2.sv
// APB slave bridging register writes/reads to a single-wire serial TX link and a
// pulse-position RX link with sync-framed 64-bit packet capture.
module apb_interface_2
  import apb_interface_2_pkg::*;
#(
  parameter int BASE_CYC   = 5000,
  parameter int SAMPLE_DLY = 100
) (
  input  logic        i_PCLK,
  input  logic        i_PRESETn,
  input  logic        i_PSEL0,
  input  logic        i_PENABLE,
  input  logic        i_PWRITE,
  input  logic [15:0] i_PADDR,
  input  logic [7:0]  i_PWDATA,
  input  logic [7:0]  i_PRDATA,
  input  logic [9:0]  i_BASE_ADDR,
  output logic [7:0]  o_PRDATA,
  output logic [7:0]  o_PWDATA,
  output logic        PREADY,
  output logic        o_WR0,
  output logic        o_WR1,
  output logic        o_WR2,
  output logic        o_WR3,
  output logic        o_DR0,
  output logic        o_DR1,
  output logic        o_DR2,
  output logic        o_DR3,
  input  logic        rfin,
  input  logic        RX,
  output logic        TX_OUT,
  output logic        pkt_rec,
  output logic        sh_en
);

  cfg_t        r_cfg;
  logic [7:0]  r_txbyte;
  logic [7:0]  r_pwdata;
  logic [7:0]  r_prdata;
  logic        r_busy;
  logic [7:0]  r_tx_sr;
  logic [2:0]  r_tx_bits;
  logic [31:0] r_tx_cnt;
  logic [1:0]  r_tx_sck;
  logic [1:0]  r_tx_slave;
  logic        r_tx_out;
  logic        r_tx_sh_en;
  logic        r_rx_avail;
  logic [63:0] r_pkt_buf;
  logic [2:0]  r_idx;
  logic [7:0]  r_rx_data;
  logic [3:0]  r_dr;
  logic        r_pkt_rec;

  logic        w_sel;
  logic        w_wr;
  logic        w_setup_rd;
  logic [5:0]  w_off;
  logic        w_start;
  logic [31:0] w_cfg_period;
  logic [31:0] w_tx_period;
  logic        w_rx_sh_en;
  logic [63:0] w_shreg;
  logic        w_match;
  logic [5:0]  w_bsel;
  logic [3:0]  w_wr_vec;
  logic        w_unused;

  assign w_sel      = i_PSEL0 && (i_PADDR[15:6] == i_BASE_ADDR);
  assign PREADY     = w_sel & i_PENABLE;
  assign w_wr       = PREADY & i_PWRITE;
  assign w_setup_rd = w_sel & ~i_PENABLE & ~i_PWRITE;
  assign w_off      = i_PADDR[5:0];
  assign w_start    = w_wr && (w_off == OFF_CMD) && i_PWDATA[CMD_START_BIT];

  assign w_cfg_period = 32'(BASE_CYC) << r_cfg.sck;
  assign w_tx_period  = 32'(BASE_CYC) << r_tx_sck;

  assign w_match  = ((w_shreg & SYNC_MASK) == SYNC_VAL);
  assign w_bsel   = {~r_idx, 3'b000};
  assign w_wr_vec = r_busy ? onehot4(r_tx_slave) : 4'b0000;
  assign w_unused = ^r_cfg.mode;

  assign {o_WR3, o_WR2, o_WR1, o_WR0} = w_wr_vec;
  assign {o_DR3, o_DR2, o_DR1, o_DR0} = r_dr;
  assign o_PRDATA = r_prdata;
  assign o_PWDATA = r_pwdata;
  assign TX_OUT   = r_tx_out;
  assign pkt_rec  = r_pkt_rec;
  assign sh_en    = r_tx_sh_en | w_rx_sh_en;

  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      r_cfg    <= CFG_RST;
      r_txbyte <= 8'd0;
      r_pwdata <= 8'd0;
      r_prdata <= 8'd0;
    end else begin
      if (w_wr) begin
        r_pwdata <= i_PWDATA;
        case (w_off)
          OFF_CFG:  r_cfg    <= cfg_t'(i_PWDATA[5:0]);
          OFF_DATA: r_txbyte <= i_PWDATA;
          default:  ;
        endcase
      end
      // Read data is captured in the setup phase so it is stable for the access phase
      if (w_setup_rd) begin
        case (w_off)
          OFF_CFG:  r_prdata <= {6'b0, r_rx_avail, r_busy};
          OFF_DATA: r_prdata <= r_rx_data;
          default:  r_prdata <= i_PRDATA;
        endcase
      end
    end
  end

  // Transmit: speed and slave are latched at START so mid-transfer CONFIG writes wait
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      r_busy     <= 1'b0;
      r_tx_sr    <= 8'd0;
      r_tx_bits  <= 3'd0;
      r_tx_cnt   <= 32'd0;
      r_tx_sck   <= 2'd0;
      r_tx_slave <= 2'd0;
      r_tx_out   <= 1'b0;
      r_tx_sh_en <= 1'b0;
    end else begin
      r_tx_sh_en <= 1'b0;
      if (r_busy) begin
        if (r_tx_cnt == 32'd0) begin
          if (r_tx_bits == 3'd7) begin
            r_busy   <= 1'b0;
            r_tx_out <= 1'b0;
          end else begin
            r_tx_bits  <= r_tx_bits + 3'd1;
            r_tx_sr    <= {r_tx_sr[6:0], 1'b0};
            r_tx_out   <= r_tx_sr[6];
            r_tx_sh_en <= 1'b1;
            r_tx_cnt   <= w_tx_period - 32'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt - 32'd1;
        end
      end else if (w_start && !RX) begin
        r_busy     <= 1'b1;
        r_tx_sck   <= r_cfg.sck;
        r_tx_slave <= r_cfg.slave;
        r_tx_sr    <= r_txbyte;
        r_tx_out   <= r_txbyte[7];
        r_tx_sh_en <= 1'b1;
        r_tx_bits  <= 3'd0;
        r_tx_cnt   <= w_cfg_period - 32'd1;
      end
    end
  end

  // Receive delivery: a fresh packet takes priority over a byte fetch
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      r_rx_avail <= 1'b0;
      r_pkt_buf  <= 64'd0;
      r_idx      <= 3'd0;
      r_rx_data  <= 8'd0;
      r_dr       <= 4'd0;
      r_pkt_rec  <= 1'b0;
    end else begin
      r_dr      <= 4'd0;
      r_pkt_rec <= w_match;
      if (w_match) begin
        r_pkt_buf  <= w_shreg;
        r_rx_avail <= 1'b1;
        r_idx      <= 3'd0;
      end else if (w_start && RX) begin
        r_rx_data <= r_pkt_buf[w_bsel +: 8];
        r_idx     <= r_idx + 3'd1;
        r_dr      <= onehot4(r_cfg.slave);
        if (r_idx == 3'd7) r_rx_avail <= 1'b0;
      end
    end
  end

  rf_bit_recovery #(
    .SAMPLE_DLY(SAMPLE_DLY)
  ) u_rx (
    .i_clk    (i_PCLK),
    .i_rst_n  (i_PRESETn),
    .i_en     (RX),
    .i_rfin   (rfin),
    .i_clr    (w_match),
    .i_period (w_cfg_period),
    .o_sh_en  (w_rx_sh_en),
    .o_shreg  (w_shreg)
  );

endmodule

// File: tb/tb_apb_interface_2.sv
// Bench for apb_interface_2 with a shortened bit period so full TX/RX runs stay short.
module tb_apb_interface_2;

  localparam int BC = 5;
  localparam int SD = 3;
  localparam int P  = BC << 3;  // CONFIG 0x0F selects SCK=11

  logic       clk = 1'b0, rstn = 1'b0;
  logic       psel = 1'b0, pen = 1'b0, pwr = 1'b0;
  logic [15:0] paddr = '0;
  logic [7:0] pwd = '0, ext = '0;
  logic [9:0] base = 10'h2C5;
  logic       rfin = 1'b0, rx = 1'b0;
  logic [7:0] prd, pwo;
  logic       pready, wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, txo, pkt, shen;

  int n_tests = 0, n_fail = 0;
  int wr3_cyc = 0, wr0_cyc = 0, pkt_cnt = 0, dr3_cnt = 0, dr_oth = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic       wr;
    logic       good;
    logic [5:0] off;
    logic [7:0] wd;
    logic [7:0] ext;
    logic [7:0] exp_rd;
    logic       exp_rdy;
    logic [7:0] exp_pw;
  } vec_t;

  apb_interface_2 #(.BASE_CYC(BC), .SAMPLE_DLY(SD)) dut (
    .i_PCLK(clk), .i_PRESETn(rstn), .i_PSEL0(psel), .i_PENABLE(pen), .i_PWRITE(pwr),
    .i_PADDR(paddr), .i_PWDATA(pwd), .i_PRDATA(ext), .i_BASE_ADDR(base),
    .o_PRDATA(prd), .o_PWDATA(pwo), .PREADY(pready),
    .o_WR0(wr0), .o_WR1(wr1), .o_WR2(wr2), .o_WR3(wr3),
    .o_DR0(dr0), .o_DR1(dr1), .o_DR2(dr2), .o_DR3(dr3),
    .rfin(rfin), .RX(rx), .TX_OUT(txo), .pkt_rec(pkt), .sh_en(shen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr3) wr3_cyc <= wr3_cyc + 1;
    if (wr0) wr0_cyc <= wr0_cyc + 1;
    if (pkt) pkt_cnt <= pkt_cnt + 1;
    if (dr3) dr3_cnt <= dr3_cnt + 1;
    if (dr0 | dr1 | dr2) dr_oth <= dr_oth + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic good, input logic [5:0] off,
                     input logic [7:0] wd, output logic [7:0] rd, output logic rdy);
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwr = wr;
    paddr = {(good ? base : base ^ 10'h001), off};
    pwd = wd;
    @(posedge clk); #1;
    pen = 1'b1;
    #2;
    rdy = pready;
    rd  = prd;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0; pwr = 1'b0;
  endtask

  initial begin
    vec_t vt[10];
    logic [7:0] rd;
    logic rdy;
    logic [7:0] txb;
    logic [63:0] pktv;
    logic [81:0] stream;
    int pkt_before;

    vt[0] = '{1'b0, 1'b1, 6'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
    vt[1] = '{1'b0, 1'b1, 6'h04, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
    vt[2] = '{1'b0, 1'b1, 6'h08, 8'h00, 8'h5A, 8'h5A, 1'b1, 8'h00};
    vt[3] = '{1'b0, 1'b0, 6'h08, 8'h00, 8'h77, 8'h5A, 1'b0, 8'h00};
    vt[4] = '{1'b0, 1'b1, 6'h0C, 8'h00, 8'hA5, 8'hA5, 1'b1, 8'h00};
    vt[5] = '{1'b1, 1'b1, 6'h04, 8'h81, 8'h00, 8'h00, 1'b1, 8'h81};
    vt[6] = '{1'b1, 1'b1, 6'h00, 8'h0F, 8'h00, 8'h00, 1'b1, 8'h0F};
    vt[7] = '{1'b1, 1'b0, 6'h04, 8'h33, 8'h00, 8'h00, 1'b0, 8'h0F};
    vt[8] = '{1'b1, 1'b0, 6'h0C, 8'h02, 8'h00, 8'h00, 1'b0, 8'h0F};
    vt[9] = '{1'b0, 1'b1, 6'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h0F};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("reset_outputs",
          64'({txo, shen, pkt, wr3, wr2, wr1, wr0, dr3, dr2, dr1, dr0, pwo, prd, pready}), 64'd0);

    // Register map vectors
    for (int i = 0; i < 10; i++) begin
      ext = vt[i].ext;
      apb(vt[i].wr, vt[i].good, vt[i].off, vt[i].wd, rd, rdy);
      check($sformatf("vec%0d_pready", i), 64'(rdy), 64'(vt[i].exp_rdy));
      if (!vt[i].wr) check($sformatf("vec%0d_prdata", i), 64'(rd), 64'(vt[i].exp_rd));
      check($sformatf("vec%0d_pwdata", i), 64'(pwo), 64'(vt[i].exp_pw));
    end

    // Transmit 0x81 to slave 3
    rx  = 1'b0;
    txb = 8'h81;
    for (int b = 7; b >= 0; b--) tx_q.push_back({7'b0, txb[b]});
    apb(1'b1, 1'b1, 6'h0C, 8'h02, rd, rdy);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int k;
          k = 0;
          while (!shen && k < 2 * P) begin
            @(posedge clk); #1;
            k++;
          end
          if (!shen) begin
            n_tests++; n_fail++;
            $display("FAIL tx_shen_timeout: bit %0d never strobed", i);
          end
          repeat (3) @(posedge clk);
          #1;
          if (tx_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_queue: bit %0d has no expected value", i);
          end else begin
            check($sformatf("tx_bit%0d", i), 64'(txo), 64'(tx_q.pop_front()));
          end
          check($sformatf("tx_wr3_bit%0d", i), 64'(wr3), 64'd1);
        end
      end
      begin
        logic [7:0] brd;
        logic brdy;
        apb(1'b0, 1'b1, 6'h00, 8'h00, brd, brdy);
        check("status_busy", 64'(brd), 64'h01);
        apb(1'b1, 1'b1, 6'h04, 8'h55, brd, brdy);  // new TX byte, START while busy
        apb(1'b1, 1'b1, 6'h0C, 8'h02, brd, brdy);
        apb(1'b1, 1'b1, 6'h00, 8'h03, brd, brdy);  // slave 0 for the next transfer
      end
    join
    repeat (P) @(posedge clk);
    #1;
    check("tx_done_txout", 64'(txo), 64'd0);
    check("tx_done_wr3", 64'(wr3), 64'd0);
    check("tx_wr3_cycles", 64'(wr3_cyc), 64'(8 * P));
    check("tx_wr0_cycles", 64'(wr0_cyc), 64'd0);
    apb(1'b0, 1'b1, 6'h00, 8'h00, rd, rdy);
    check("status_idle", 64'(rd), 64'h00);

    // Receive: alternating preamble then the sync-framed packet
    apb(1'b1, 1'b1, 6'h00, 8'h0F, rd, rdy);
    rx = 1'b1;
    repeat (100) @(posedge clk);
    pktv   = 64'hFDD4_EC5F_595B_51FF;
    stream = {18'h2AAAA, pktv};
    pkt_before = -1;
    for (int b = 81; b >= 0; b--) begin
      if (b == 0) pkt_before = pkt_cnt;
      for (int c = 0; c < P; c++) begin
        @(posedge clk); #1;
        rfin = stream[b] && (c == P - 4 || c == P - 3);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check("pkt_before_last_bit", 64'(pkt_before), 64'd0);
    check("pkt_rec_count", 64'(pkt_cnt), 64'd1);
    apb(1'b0, 1'b1, 6'h00, 8'h00, rd, rdy);
    check("status_rx_avail", 64'(rd), 64'h02);

    for (int i = 0; i < 8; i++) begin
      rx_q.push_back(pktv[63 - 8 * i -: 8]);
      apb(1'b1, 1'b1, 6'h0C, 8'h02, rd, rdy);
      apb(1'b0, 1'b1, 6'h04, 8'h00, rd, rdy);
      if (rx_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rx_queue: byte %0d has no expected value", i);
      end else begin
        check($sformatf("rx_byte%0d", i), 64'(rd), 64'(rx_q.pop_front()));
      end
    end
    check("rx_dr3_pulses", 64'(dr3_cnt), 64'd8);
    check("rx_dr_other", 64'(dr_oth), 64'd0);
    check("pkt_rec_no_repeat", 64'(pkt_cnt), 64'd1);
    apb(1'b0, 1'b1, 6'h00, 8'h00, rd, rdy);
    check("status_rx_drained", 64'(rd), 64'h00);

    // Reset in the middle of a transfer
    rx = 1'b0;
    apb(1'b1, 1'b1, 6'h04, 8'hFF, rd, rdy);
    apb(1'b1, 1'b1, 6'h0C, 8'h02, rd, rdy);
    repeat (P + 10) @(posedge clk);
    #1;
    check("pre_reset_tx", 64'({txo, wr3}), 64'b11);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("reset_abort", 64'({txo, wr3, shen, pwo}), 64'd0);
    rstn = 1'b1;
    apb(1'b0, 1'b1, 6'h00, 8'h00, rd, rdy);
    check("reset_status", 64'(rd), 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
